// File: rtl/mmio_led_pwm_ctrl_pkg.sv
// Shared definitions for the LED/PWM/cycle-counter/tohost MMIO peripheral:
// register offsets, access-size encoding and the byte-lane decoder.
package mmio_led_pwm_ctrl_pkg;

    typedef enum logic [2:0] {
        F3_BYTE  = 3'b000,
        F3_HALF  = 3'b001,
        F3_WORD  = 3'b010,
        F3_BYTEU = 3'b100,
        F3_HALFU = 3'b101
    } funct3_mem_t;

    localparam logic [12:0] MMIO_OFF_LED_EN    = 13'h000;
    localparam logic [12:0] MMIO_OFF_CYCLE_LO  = 13'h004;
    localparam logic [12:0] MMIO_OFF_CYCLE_HI  = 13'h008;
    localparam logic [12:0] MMIO_OFF_PWM_CNT   = 13'h00C;
    localparam logic [12:0] MMIO_OFF_DUTY_BASE = 13'h100;
    localparam logic [12:0] MMIO_OFF_TOHOST    = 13'h1000;

    localparam logic [31:0] MMIO_WINDOW_SIZE = 32'h2000;

    typedef struct packed {
        logic [3:0] be;
        logic       misaligned;
    } be_t;

    // Unsigned load variants share the lane pattern of their signed forms.
    function automatic be_t be_from_funct3(input logic [2:0] funct3, input logic [1:0] addr_lo);
        be_t r;
        r.be         = 4'b0000;
        r.misaligned = 1'b0;
        case (funct3)
            F3_BYTE, F3_BYTEU: r.be = 4'b0001 << addr_lo;
            F3_HALF, F3_HALFU: begin
                r.be         = 4'b0011 << addr_lo;
                r.misaligned = addr_lo[0];
            end
            F3_WORD: begin
                r.be         = 4'b1111;
                r.misaligned = |addr_lo;
            end
            default: r.misaligned = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mmio_led_pwm_ctrl_pwm_channel.sv
// One PWM output: compares the shared counter against this channel's duty
// and registers the result so the pin never sees compare glitches.
module mmio_led_pwm_ctrl_pwm_channel #(
    parameter int unsigned PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_en,
    input  logic [PWM_BITS-1:0] i_duty,
    input  logic [PWM_BITS-1:0] i_cnt,
    output logic                o_led
);

    logic r_led;
    logic w_on;

    // All-ones duty is held on so full brightness has no one-step dropout.
    assign w_on = i_en & ((i_cnt < i_duty) | (&i_duty));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_led <= 1'b0;
        end else begin
            r_led <= w_on;
        end
    end

    assign o_led = r_led;

endmodule

// File: rtl/mmio_led_pwm_ctrl.sv
// MMIO peripheral on the MEM-stage data port: LED enables with per-channel PWM,
// 64-bit cycle counter with high-word snapshot, and a sticky tohost register.
module mmio_led_pwm_ctrl
    import mmio_led_pwm_ctrl_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int unsigned N_CH      = 4,
    parameter int unsigned PWM_BITS  = 8,
    parameter int unsigned PRESCALE  = 16,
    parameter int unsigned XLEN      = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] addr_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic            we_i,
    input  logic            re_i,
    input  logic [2:0]      funct3_i,
    output logic [XLEN-1:0] rdata_o,
    output logic            rvalid_o,
    output logic            err_o,
    output logic [N_CH-1:0] led_o,
    output logic [XLEN-1:0] tohost_o,
    output logic            tohost_valid_o
);

    localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic [63:0]          r_cycle;
    logic [31:0]          r_snap;
    logic [PRE_W-1:0]     r_pre;
    logic [PWM_BITS-1:0]  r_pwm;
    logic [N_CH-1:0]      r_led_en;
    logic [PWM_BITS-1:0]  r_duty [N_CH];
    logic [XLEN-1:0]      r_tohost;
    logic                 r_tohost_valid;
    logic [XLEN-1:0]      r_rdata;
    logic                 r_rvalid;
    logic                 r_err;

    logic [XLEN-1:0] w_off_full;
    logic [12:0]     w_off;
    logic            w_hit;
    be_t             w_be;
    logic [XLEN-1:0] w_mask;
    logic            w_sel_en, w_sel_lo, w_sel_hi, w_sel_cnt, w_sel_duty, w_sel_tohost;
    logic            w_bad;
    logic            w_wr_ok;
    logic            w_rd_ok;
    logic [CH_W-1:0] w_duty_idx;
    logic [XLEN-1:0] w_rd;
    logic [XLEN-1:0] w_new;

    // Unsigned subtract doubles as the window bound check on both sides.
    assign w_off_full = addr_i - BASE_ADDR;
    assign w_hit      = w_off_full < MMIO_WINDOW_SIZE;
    assign w_off      = {w_off_full[12:2], 2'b00};
    assign w_be       = be_from_funct3(funct3_i, addr_i[1:0]);

    assign w_sel_en     = (w_off == MMIO_OFF_LED_EN);
    assign w_sel_lo     = (w_off == MMIO_OFF_CYCLE_LO);
    assign w_sel_hi     = (w_off == MMIO_OFF_CYCLE_HI);
    assign w_sel_cnt    = (w_off == MMIO_OFF_PWM_CNT);
    assign w_sel_duty   = (w_off >= MMIO_OFF_DUTY_BASE) &&
                          (w_off < (MMIO_OFF_DUTY_BASE + 13'(4 * N_CH)));
    assign w_sel_tohost = (w_off == MMIO_OFF_TOHOST);
    assign w_duty_idx   = w_off[2 +: CH_W];

    assign w_bad   = w_be.misaligned |
                     ~(w_sel_en | w_sel_lo | w_sel_hi | w_sel_cnt | w_sel_duty | w_sel_tohost);
    assign w_wr_ok = w_hit & we_i & ~w_bad;
    assign w_rd_ok = w_hit & re_i & ~w_bad;

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < 4; i++) begin
            w_mask[8*i +: 8] = {8{w_be.be[i]}};
        end
    end

    always_comb begin
        w_rd = '0;
        if (!w_bad) begin
            if (w_sel_en) begin
                w_rd[N_CH-1:0] = r_led_en;
            end else if (w_sel_lo) begin
                w_rd = r_cycle[31:0];
            end else if (w_sel_hi) begin
                w_rd = r_snap;
            end else if (w_sel_cnt) begin
                w_rd[PWM_BITS-1:0] = r_pwm;
            end else if (w_sel_duty) begin
                w_rd[PWM_BITS-1:0] = r_duty[w_duty_idx];
            end else if (w_sel_tohost) begin
                w_rd = r_tohost;
            end
        end
    end

    // Read-modify-write against the current word; each target keeps its own slice.
    assign w_new = (w_rd & ~w_mask) | (wdata_i & w_mask);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cycle        <= '0;
            r_snap         <= '0;
            r_pre          <= '0;
            r_pwm          <= '0;
            r_led_en       <= '0;
            r_tohost       <= '0;
            r_tohost_valid <= 1'b0;
            r_rdata        <= '0;
            r_rvalid       <= 1'b0;
            r_err          <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                r_duty[i] <= '0;
            end
        end else begin
            r_cycle  <= r_cycle + 64'd1;
            r_rvalid <= w_hit & re_i;
            r_err    <= w_hit & (we_i | re_i) & w_bad;

            if (w_hit && re_i) begin
                r_rdata <= w_rd;
            end
            if (w_rd_ok && w_sel_lo) begin
                r_snap <= r_cycle[63:32];
            end

            if (r_pre == PRE_W'(PRESCALE - 1)) begin
                r_pre <= '0;
                r_pwm <= r_pwm + 1'b1;
            end else begin
                r_pre <= r_pre + 1'b1;
            end

            if (w_wr_ok) begin
                if (w_sel_en) begin
                    r_led_en <= w_new[N_CH-1:0];
                end
                if (w_sel_duty) begin
                    r_duty[w_duty_idx] <= w_new[PWM_BITS-1:0];
                end
                if (w_sel_tohost) begin
                    r_tohost       <= w_new;
                    r_tohost_valid <= 1'b1;
                end
            end
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        mmio_led_pwm_ctrl_pwm_channel #(
            .PWM_BITS(PWM_BITS)
        ) u_ch (
            .clk   (clk),
            .rst_n (rst_n),
            .i_en  (r_led_en[g]),
            .i_duty(r_duty[g]),
            .i_cnt (r_pwm),
            .o_led (led_o[g])
        );
    end

    assign rdata_o        = r_rdata;
    assign rvalid_o       = r_rvalid;
    assign err_o          = r_err;
    assign tohost_o       = r_tohost;
    assign tohost_valid_o = r_tohost_valid;

endmodule

// File: tb/tb_mmio_led_pwm_ctrl.sv
// Self-checking bench: behavioural register/PWM model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mmio_led_pwm_ctrl;

    localparam logic [31:0] BASE     = 32'h8000_0000;
    localparam int unsigned N_CH     = 4;
    localparam int unsigned PWM_BITS = 8;
    localparam int unsigned PRESCALE = 1;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [31:0]     addr_i, wdata_i;
    logic            we_i, re_i;
    logic [2:0]      funct3_i;
    logic [31:0]     rdata_o;
    logic            rvalid_o, err_o;
    logic [N_CH-1:0] led_o;
    logic [31:0]     tohost_o;
    logic            tohost_valid_o;

    mmio_led_pwm_ctrl #(
        .BASE_ADDR(BASE),
        .N_CH     (N_CH),
        .PWM_BITS (PWM_BITS),
        .PRESCALE (PRESCALE),
        .XLEN     (32)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .addr_i        (addr_i),
        .wdata_i       (wdata_i),
        .we_i          (we_i),
        .re_i          (re_i),
        .funct3_i      (funct3_i),
        .rdata_o       (rdata_o),
        .rvalid_o      (rvalid_o),
        .err_o         (err_o),
        .led_o         (led_o),
        .tohost_o      (tohost_o),
        .tohost_valid_o(tohost_valid_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    function automatic void chk(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Behavioural model state
    logic [N_CH-1:0]     m_en = '0;
    logic [PWM_BITS-1:0] m_duty [N_CH];
    logic [31:0]         m_tohost = '0;
    logic                m_tv = 1'b0;
    logic [63:0]         m_cycle = '0;
    logic [31:0]         m_snap = '0;
    int unsigned         m_ticks = 0;
    logic [31:0]         exp_rdata = '0;
    logic                exp_rvalid = 1'b0, exp_err = 1'b0;
    logic [N_CH-1:0]     exp_led = '0;
    logic                preload_en = 1'b0;
    logic [63:0]         preload_val = '0;

    task automatic model_step();
        logic [31:0] off, word, val, nv;
        int          nbytes, lane0, idx;
        int unsigned pwm;
        bit          hit, ok;
        if (!rst_n) begin
            m_en = '0; m_tohost = '0; m_tv = 1'b0; m_cycle = '0; m_snap = '0;
            m_ticks = 0; exp_rdata = '0; exp_rvalid = 1'b0; exp_err = 1'b0; exp_led = '0;
            for (int c = 0; c < N_CH; c++) m_duty[c] = '0;
            return;
        end
        if (preload_en) m_cycle = preload_val;
        pwm = (m_ticks / PRESCALE) % (1 << PWM_BITS);
        for (int c = 0; c < N_CH; c++)
            exp_led[c] = m_en[c] && ((pwm < m_duty[c]) || (m_duty[c] == (1 << PWM_BITS) - 1));
        hit   = (addr_i >= BASE) && (addr_i <= BASE + 32'h1FFF);
        off   = addr_i - BASE;
        word  = off & 32'hFFFF_FFFC;
        lane0 = int'(addr_i[1:0]);
        case (funct3_i)
            3'd0, 3'd4: nbytes = 1;
            3'd1, 3'd5: nbytes = 2;
            3'd2:       nbytes = 4;
            default:    nbytes = 0;
        endcase
        ok  = (nbytes != 0) ? ((lane0 % nbytes) == 0) : 1'b0;
        val = '0;
        idx = 0;
        if (word == 32'h0) val = 32'(m_en);
        else if (word == 32'h4) val = m_cycle[31:0];
        else if (word == 32'h8) val = m_snap;
        else if (word == 32'hC) val = pwm;
        else if (word >= 32'h100 && word < 32'h100 + 4 * N_CH) begin
            idx = int'((word - 32'h100) / 4);
            val = 32'(m_duty[idx]);
        end else if (word == 32'h1000) val = m_tohost;
        else ok = 1'b0;
        exp_rvalid = hit && re_i;
        if (hit && re_i) exp_rdata = ok ? val : 32'h0;
        exp_err = hit && (re_i || we_i) && !ok;
        if (hit && re_i && ok && word == 32'h4) m_snap = m_cycle[63:32];
        if (hit && we_i && ok) begin
            nv = val;
            for (int b = lane0; b < lane0 + nbytes; b++) nv[8*b +: 8] = wdata_i[8*b +: 8];
            if (word == 32'h0) m_en = nv[N_CH-1:0];
            else if (word >= 32'h100 && word < 32'h100 + 4 * N_CH) m_duty[idx] = nv[PWM_BITS-1:0];
            else if (word == 32'h1000) begin
                m_tohost = nv;
                m_tv     = 1'b1;
            end
        end
        m_cycle = m_cycle + 1;
        m_ticks = m_ticks + 1;
    endtask

    always @(posedge clk or negedge rst_n) model_step();

    always @(negedge clk) begin
        if (rst_n) begin
            chk("cyc_rdata", 64'(rdata_o), 64'(exp_rdata));
            chk("cyc_rvalid", 64'(rvalid_o), 64'(exp_rvalid));
            chk("cyc_err", 64'(err_o), 64'(exp_err));
            chk("cyc_led", 64'(led_o), 64'(exp_led));
            chk("cyc_tohost", 64'(tohost_o), 64'(m_tohost));
            chk("cyc_tohost_valid", 64'(tohost_valid_o), 64'(m_tv));
        end
    end

    task automatic bus(input logic w, input logic r, input logic [31:0] a,
                       input logic [2:0] f, input logic [31:0] d);
        @(negedge clk);
        we_i = w; re_i = r; addr_i = a; funct3_i = f; wdata_i = d;
        @(negedge clk);
        we_i = 1'b0; re_i = 1'b0;
    endtask

    logic [31:0] offs [9] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h100, 32'h104, 32'h108,
                              32'h10C, 32'h1000};
    logic [2:0]  f3s [8] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd2, 3'd2, 3'd3};

    initial begin
        int   cnt;
        logic [63:0] first, second;
        logic [31:0] a;
        rst_n = 1'b0; we_i = 1'b0; re_i = 1'b0; addr_i = '0; wdata_i = '0; funct3_i = '0;
        #3;
        chk("rst_rvalid", 64'(rvalid_o), 64'h0);
        chk("rst_err", 64'(err_o), 64'h0);
        chk("rst_led", 64'(led_o), 64'h0);
        chk("rst_tohost", 64'(tohost_o), 64'h0);
        chk("rst_tohost_valid", 64'(tohost_valid_o), 64'h0);
        chk("rst_rdata", 64'(rdata_o), 64'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // All channels enabled at full duty, then channel 1 at zero duty
        bus(1, 0, BASE + 32'h0, 3'd2, 32'h0000_000F);
        for (int c = 0; c < N_CH; c++) bus(1, 0, BASE + 32'h100 + 4 * c, 3'd2, 32'hFF);
        repeat (2) @(negedge clk);
        chk("led_all_on", 64'(led_o), 64'hF);
        bus(1, 0, BASE + 32'h104, 3'd2, 32'h0);
        @(negedge clk);
        cnt = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (led_o != 4'b1101) cnt++;
        end
        chk("led_duty0_off", 64'(cnt), 64'd0);

        // Quarter duty: 64 high cycles per 256-step period
        bus(1, 0, BASE + 32'h108, 3'd2, 32'h40);
        @(negedge clk);
        cnt = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            if (led_o[2]) cnt++;
        end
        chk("pwm_64_of_256", 64'(cnt), 64'd64);

        // Byte store to TOHOST lane 2, then a word store
        bus(1, 0, BASE + 32'h1002, 3'd0, 32'h00AB_0000);
        chk("tohost_sb", 64'(tohost_o), 64'h00AB_0000);
        chk("tohost_valid_set", 64'(tohost_valid_o), 64'h1);
        bus(1, 0, BASE + 32'h1000, 3'd2, 32'h1);
        chk("tohost_sw", 64'(tohost_o), 64'h1);
        chk("tohost_valid_sticky", 64'(tohost_valid_o), 64'h1);

        // Counter low-word wrap: LO and snapshot must form one coherent 64-bit value
        @(negedge clk);
        force dut.r_cycle = 64'h0000_0000_FFFF_FFFF;
        preload_val = 64'h0000_0000_FFFF_FFFF;
        preload_en  = 1'b1;
        addr_i = BASE + 32'h4; funct3_i = 3'd2; re_i = 1'b1;
        #1 release dut.r_cycle;
        @(negedge clk);
        preload_en = 1'b0; re_i = 1'b0;
        first[31:0] = rdata_o;
        chk("cycle_lo_pre_wrap", 64'(rdata_o), 64'hFFFF_FFFF);
        bus(0, 1, BASE + 32'h8, 3'd2, 32'h0);
        first[63:32] = rdata_o;
        chk("cycle_hi_pre_wrap", 64'(rdata_o), 64'h0);
        bus(0, 1, BASE + 32'h4, 3'd2, 32'h0);
        second[31:0] = rdata_o;
        chk("cycle_lo_post_wrap", 64'(rdata_o), 64'h3);
        bus(0, 1, BASE + 32'h8, 3'd2, 32'h0);
        second[63:32] = rdata_o;
        chk("cycle_hi_post_wrap", 64'(rdata_o), 64'h1);
        chk("cycle_delta", second - first, 64'd4);

        // Misaligned and unmapped accesses
        bus(0, 1, BASE + 32'h1, 3'd1, 32'h0);
        chk("lh_mis_rdata", 64'(rdata_o), 64'h0);
        chk("lh_mis_rvalid", 64'(rvalid_o), 64'h1);
        chk("lh_mis_err", 64'(err_o), 64'h1);
        bus(0, 1, BASE + 32'h4, 3'd2, 32'h0);
        bus(0, 1, BASE + 32'hFC, 3'd2, 32'h0);
        chk("lw_unmap_rdata", 64'(rdata_o), 64'h0);
        chk("lw_unmap_rvalid", 64'(rvalid_o), 64'h1);
        chk("lw_unmap_err", 64'(err_o), 64'h1);
        bus(1, 0, BASE + 32'h1, 3'd1, 32'h0);
        chk("sh_mis_err", 64'(err_o), 64'h1);
        bus(0, 1, BASE + 32'h0, 3'd2, 32'h0);
        chk("led_en_unchanged", 64'(rdata_o), 64'hF);
        bus(0, 1, BASE + 32'h2000, 3'd2, 32'h0);
        chk("miss_no_rvalid", 64'(rvalid_o), 64'h0);
        chk("miss_no_err", 64'(err_o), 64'h0);

        // Randomized traffic with one asynchronous reset in the middle
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (i == 1500) begin
                #2 rst_n = 1'b0;
                #4 rst_n = 1'b1;
            end
            case ($urandom % 8)
                0, 1, 2, 3, 4: a = BASE + offs[$urandom % 9] + ($urandom % 4);
                5:             a = BASE + ($urandom % 32'h2000);
                6:             a = ($urandom % 2) ? BASE - 1 - ($urandom % 16)
                                                  : BASE + 32'h2000 + ($urandom % 16);
                default:       a = BASE + 32'h100 + ($urandom % 8) * 4;
            endcase
            addr_i   = a;
            funct3_i = f3s[$urandom % 8];
            wdata_i  = $urandom;
            we_i     = (($urandom % 3) == 0);
            re_i     = $urandom % 2;
        end
        @(negedge clk);
        we_i = 1'b0; re_i = 1'b0;

        // Asynchronous reset during a read response with a lit LED
        bus(1, 0, BASE + 32'h0, 3'd2, 32'h1);
        bus(1, 0, BASE + 32'h100, 3'd2, 32'hFF);
        bus(1, 0, BASE + 32'h1000, 3'd2, 32'h5A);
        repeat (2) @(negedge clk);
        addr_i = BASE + 32'h0; funct3_i = 3'd2; re_i = 1'b1;
        @(posedge clk);
        #1 re_i = 1'b0;
        chk("pre_rst_rvalid", 64'(rvalid_o), 64'h1);
        chk("pre_rst_led0", 64'(led_o[0]), 64'h1);
        chk("pre_rst_tv", 64'(tohost_valid_o), 64'h1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_rvalid", 64'(rvalid_o), 64'h0);
        chk("async_rst_led", 64'(led_o), 64'h0);
        chk("async_rst_tv", 64'(tohost_valid_o), 64'h0);
        chk("async_rst_tohost", 64'(tohost_o), 64'h0);
        chk("async_rst_rdata", 64'(rdata_o), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mmio_led_pwm_ctrl.md
Name: mmio_led_pwm_ctrl

Overview:
- Parametrised successor to the single fixed-width LED/tohost MMIO pair.
- Memory-mapped peripheral on the MEM-stage data port. Provides:
  - N_CH LED channels, each with an enable and a PWM duty register.
  - A 64-bit free-running cycle counter with an atomic high-word snapshot.
  - A sticky tohost register for simulation exit.
- Sits beside data RAM. The MEM stage drives it whenever an access falls inside its address window.

Parameters:
- BASE_ADDR, MMIO_LED_ADDR (0x8000_0000), base of the register window.
- N_CH, LED_WIDTH (4), number of LED/PWM channels, 1..32.
- PWM_BITS, 8, duty/counter width, 1..16.
- PRESCALE, 16, clocks per PWM counter step, >=1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- addr_i  in  XLEN  byte address from MEM stage
- wdata_i  in  XLEN  store data, already aligned to byte lanes
- we_i  in  1  store strobe, single cycle
- re_i  in  1  load strobe, single cycle
- funct3_i  in  3  access size, funct3_mem_t
- rdata_o  out  XLEN  registered read word
- rvalid_o  out  1  rdata_o valid, one cycle after re_i
- err_o  out  1  misaligned or unmapped access, one-cycle pulse
- led_o  out  N_CH  PWM-modulated LED drive
- tohost_o  out  XLEN  last value written to TOHOST
- tohost_valid_o  out  1  sticky, set on the first TOHOST write

Behaviour:
- Hit condition: addr_i in [BASE_ADDR, BASE_ADDR+0x1FFF]. When not hit, strobes are ignored, no response, no err.
- Register map, offsets from BASE_ADDR:
  - 0x000 LED_EN, RW, bits [N_CH-1:0], upper bits read 0.
  - 0x004 CYCLE_LO, RO. A read also latches CYCLE_HI into the snapshot register.
  - 0x008 CYCLE_HI_SNAP, RO, holds the snapshot.
  - 0x00C PWM_CNT, RO, current PWM counter.
  - 0x100+4*ch DUTY[ch], RW, [PWM_BITS-1:0].
  - 0x1000 TOHOST, RW.
  - Any other offset in the window is unmapped.
- Byte enables:
  - F3_BYTE gives 1 lane at addr[1:0].
  - F3_HALF gives 2 lanes and requires addr[0]=0.
  - F3_WORD gives 4 lanes and requires addr[1:0]=0.
  - Register update: new = (old & ~mask) | (wdata_i & mask).
- Loads always return the full aligned word; sign/zero extension stays in the LSU.
- Read latency is exactly 1 cycle: rdata_o and rvalid_o are registered. rvalid_o is high for one cycle, and rdata_o holds its value until the next read.
- Misaligned or unmapped access:
  - Write is dropped.
  - A read returns 0 with rvalid_o=1.
  - err_o pulses 1 cycle later, aligned with rvalid_o.
- we_i and re_i together: the write takes effect, and the read returns the pre-write value.
- Cycle counter:
  - 64-bit, increments every clock, wraps 2^64-1 to 0.
  - A CYCLE_LO read returns the counter value at the read cycle and snapshots the upper 32 bits from the same cycle.
- PWM:
  - A prescaler counts 0..PRESCALE-1. The PWM counter steps on the prescaler terminal count and wraps 2^PWM_BITS-1 to 0.
  - led_o[ch] = LED_EN[ch] & ((PWM_CNT < DUTY[ch]) | (DUTY[ch] == all-ones)).
  - DUTY=0 means always off. DUTY all-ones means constant on.
  - Outputs are registered, glitch-free, 1-cycle lag.
- TOHOST: any accepted write updates tohost_o and sets tohost_valid_o. tohost_valid_o is cleared only by reset.
- Reset, asynchronous and usable mid-operation: every register and output goes to 0, including rvalid_o, err_o, led_o, tohost_o, tohost_valid_o, counters and snapshot. Nothing is pending after reset.

Decomposition:
- Add to riscv_pkg:
  - Offsets MMIO_OFF_LED_EN, MMIO_OFF_CYCLE_LO, MMIO_OFF_CYCLE_HI, MMIO_OFF_PWM_CNT, MMIO_OFF_DUTY_BASE, MMIO_OFF_TOHOST.
  - MMIO_WINDOW_SIZE = 32'h2000.
  - Function be_from_funct3(funct3, addr_lo) returning a 4-bit lane mask plus a misaligned flag.
- Sub-module pwm_channel: holds the duty compare and output register per channel, instantiated N_CH times off a shared counter.

Test Plan:
- Reset, then SW 0x0000_000F to 0x000 and SW 0xFF to DUTY[0..3] -> led_o=4'hF constant. With DUTY[1]=0, led_o[1] stays 0.
- DUTY[2]=0x40, PRESCALE=1, PWM_BITS=8 -> led_o[2] is high for exactly 64 of every 256 cycles.
- SB 0xAB to 0x1000+2 -> tohost_o=0x00AB_0000, tohost_valid_o=1. A later SW 0x1 gives tohost_o=0x1 with valid still 1.
- Preload counter near 0x0000_0000_FFFF_FFFF via force, read LO at the wrap edge -> LO and HI_SNAP form a consistent 64-bit value.
- LH from 0x001 and LW from 0x0FC -> rdata_o=0, rvalid_o=1, err_o=1. Registers are unchanged.
- Assert rst_n=0 during an active read and mid-PWM -> rvalid_o, led_o and tohost_valid_o drop immediately, without waiting for a clock edge.
